ram_arb: RTL and testbench
==========================

Name: ram_arb

Overview:
- Two-requester arbiter that shares the single-port-per-direction data RAM between the instruction fetch unit (m0, read-only) and the load/store unit (m1, read/write).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The RAM read path is combinational. The arbiter registers read data into a response buffer, so at most one transaction is in flight at a time.
- The block sits between the IFU/LSU and the ram instance.

Parameters:
- ADDR_W, 32, address width (matches `ADDR_WIDTH).
- DATA_W, 32, data width (matches `DATA_WIDTH); the write mask is DATA_W/8 bits.

Ports:
- i_sys_clk  in  1  clock; one clock domain only.
- i_sys_rst_n  in  1  reset; synchronous, active-low.
- i_m0_req_valid  in  1  fetch read request.
- o_m0_req_ready  out  1  fetch request accepted this cycle.
- i_m0_req_addr  in  ADDR_W  fetch byte address.
- o_m0_rsp_valid  out  1  fetch response available.
- i_m0_rsp_ready  in  1  fetch response consumed.
- o_m0_rsp_data  out  DATA_W  fetched word.
- i_m1_req_valid  in  1  LSU request.
- o_m1_req_ready  out  1  LSU request accepted.
- i_m1_req_wr  in  1  1 = write, 0 = read.
- i_m1_req_addr  in  ADDR_W  LSU byte address.
- i_m1_req_wdata  in  DATA_W  write data.
- i_m1_req_wmask  in  DATA_W/8  byte enables.
- o_m1_rsp_valid  out  1  LSU response available (read data or write ack).
- i_m1_rsp_ready  in  1  LSU response consumed.
- o_m1_rsp_data  out  DATA_W  read data; 0 for a write ack.
- o_ram_rd_en  out  1  to ram read enable.
- o_ram_rd_addr  out  ADDR_W  to ram read address.
- i_ram_rd_data  in  DATA_W  from ram; combinational, 0 when rd_en = 0.
- o_ram_wr_en  out  1  to ram write enable.
- o_ram_wr_addr  out  ADDR_W  to ram write address.
- o_ram_wr_data  out  DATA_W  to ram write data.
- o_ram_wr_mask  out  DATA_W/8  to ram byte mask.

Behaviour:
- State machine, two states: S_IDLE and S_RESP. Registers: r_state, r_owner (0 = m0, 1 = m1), r_rsp_data, r_last_grant.
- Reset (i_sys_rst_n = 0 at a clock edge):
  - r_state = S_IDLE, r_rsp_data = 0, r_last_grant = 1 (so m0 wins the first conflict), r_owner = 0.
  - While reset is low, the following are forced to 0 combinationally: both rsp_valid, both req_ready, o_ram_rd_en, o_ram_wr_en.
  - A pending response is discarded; no RAM write may occur in a reset cycle.
- S_IDLE arbitration (combinational):
  - Only m0 valid → grant m0. Only m1 valid → grant m1.
  - Both valid → grant the master that is not r_last_grant (round-robin).
- S_IDLE, grant issued:
  - Assert the granted master's req_ready in the same cycle (ready depends on valid; a requester's valid must never depend on its ready).
  - Drive the RAM from the granted request. A read drives o_ram_rd_en = 1 and o_ram_rd_addr = addr. An m1 write drives o_ram_wr_en = 1 with addr, wdata and wmask.
  - At the clock edge: r_rsp_data ← i_ram_rd_data for a read, 0 for a write. r_owner ← granted master, r_last_grant ← granted master, r_state ← S_RESP.
- S_IDLE, no valid request: all RAM enables are 0, all RAM address/data/mask outputs are 0, and r_state stays S_IDLE.
- S_RESP:
  - Assert rsp_valid only to r_owner; rsp_data = r_rsp_data. Hold both until that master's rsp_ready = 1.
  - On the handshake edge, r_state ← S_IDLE.
  - No new request is accepted in S_RESP, including the handshake cycle. Both req_ready = 0 and RAM enables = 0.
- Latency and throughput:
  - Request accept to rsp_valid: 1 cycle.
  - Best-case throughput: 1 transaction per 2 cycles.
- Write-after-read ordering is inherent: only one transaction is outstanding.
- A write with wmask = 0 still completes and is acked; the RAM contents are unchanged.
- Requester rule: request fields must stay stable while valid = 1 and ready = 0. The arbiter does not latch requests.
- Response data of the non-owner is 0 whenever its rsp_valid = 0.

Decomposition:
- Package ram_arb_pkg: state enum (S_IDLE, S_RESP) and master-id enum (M_IFU = 0, M_LSU = 1).
- Sub-module rr_arb2: combinational 2-way round-robin pick. Inputs are the two valids and last_grant; outputs are grant_valid and grant_id.
- The state machine and response register stay in ram_arb.

Test Plan:
- Reset, then a single m0 read of 0x8000_0004 with RAM word 0xDEAD_BEEF → o_m0_req_ready = 1 in cycle 0; o_m0_rsp_valid = 1 with data 0xDEAD_BEEF in cycle 1; o_m1_rsp_valid stays 0.
- m0 and m1 both valid right after reset → m0 granted first (r_last_grant = 1). After m0's response is accepted, m1 is granted. Alternation continues with both held valid: m0, m1, m0, m1.
- m1 write to 0x8000_0010, wdata 0x1122_3344, wmask 0b0101, then an m1 read of the same address over 0xAAAA_AAAA → write ack carries data 0; the read returns 0xAA22_AA44.
- Response backpressure: m0 read accepted, i_m0_rsp_ready held 0 for 3 cycles while m1 is valid → rsp_valid and data are stable, o_m1_req_ready = 0, RAM enables = 0. m1 is granted in the first S_IDLE cycle after the m0 handshake.
- Reset asserted in S_RESP, with m1 write valid in the same cycle → next cycle rsp_valid = 0 and the state is S_IDLE. o_ram_wr_en = 0 during reset, so the target RAM word is unchanged.
- Write with wmask = 0 → ack returned one cycle after accept; a subsequent read shows the original word.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package ram_arb_pkg;

    // Arbiter state: waiting for a request, or holding a response for its owner.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    // Requester identity: instruction fetch (read-only) or load/store unit.
    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } master_e;

endpackage

// File: rtl/ram_arb_rr_arb2.sv
// Combinational two-way round-robin pick between the IFU and the LSU.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Single requester wins outright; on a conflict the one not served last wins.
    always_comb begin
        grant_valid = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            grant_id = (last_grant == M_IFU) ? M_LSU : M_IFU;
        end else if (m1_valid) begin
            grant_id = M_LSU;
        end else begin
            grant_id = M_IFU;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Shares the data RAM between the IFU (m0, read-only) and the LSU (m1,
// read/write). One transaction in flight: the request is driven straight to
// the RAM, read data is captured into a response buffer, and the response is
// held for the owning requester until it is consumed.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_m0_req_valid,
    output logic                  o_m0_req_ready,
    input  logic [ADDR_W-1:0]     i_m0_req_addr,
    output logic                  o_m0_rsp_valid,
    input  logic                  i_m0_rsp_ready,
    output logic [DATA_W-1:0]     o_m0_rsp_data,
    input  logic                  i_m1_req_valid,
    output logic                  o_m1_req_ready,
    input  logic                  i_m1_req_wr,
    input  logic [ADDR_W-1:0]     i_m1_req_addr,
    input  logic [DATA_W-1:0]     i_m1_req_wdata,
    input  logic [DATA_W/8-1:0]   i_m1_req_wmask,
    output logic                  o_m1_rsp_valid,
    input  logic                  i_m1_rsp_ready,
    output logic [DATA_W-1:0]     o_m1_rsp_data,
    output logic                  o_ram_rd_en,
    output logic [ADDR_W-1:0]     o_ram_rd_addr,
    input  logic [DATA_W-1:0]     i_ram_rd_data,
    output logic                  o_ram_wr_en,
    output logic [ADDR_W-1:0]     o_ram_wr_addr,
    output logic [DATA_W-1:0]     o_ram_wr_data,
    output logic [DATA_W/8-1:0]   o_ram_wr_mask
);

    localparam int MASK_W = DATA_W / 8;

    state_e              r_state;
    master_e             r_owner;
    master_e             r_last_grant;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                grant_valid_s;
    logic                grant_id_s;
    logic                is_wr_s;
    logic                rsp_hs_s;

    rr_arb2 u_rr_arb2 (
        .m0_valid    (i_m0_req_valid),
        .m1_valid    (i_m1_req_valid),
        .last_grant  (r_last_grant),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // A write only ever comes from the LSU; response handshake is the owner's ready.
    always_comb begin
        is_wr_s  = (grant_id_s == M_LSU) && i_m1_req_wr;
        rsp_hs_s = (r_owner == M_LSU) ? i_m1_rsp_ready : i_m0_rsp_ready;
    end

    // Handshakes and RAM drive; everything quiet while reset is held low.
    always_comb begin
        o_m0_req_ready = 1'b0;
        o_m1_req_ready = 1'b0;
        o_m0_rsp_valid = 1'b0;
        o_m1_rsp_valid = 1'b0;
        o_m0_rsp_data  = {DATA_W{1'b0}};
        o_m1_rsp_data  = {DATA_W{1'b0}};
        o_ram_rd_en    = 1'b0;
        o_ram_rd_addr  = {ADDR_W{1'b0}};
        o_ram_wr_en    = 1'b0;
        o_ram_wr_addr  = {ADDR_W{1'b0}};
        o_ram_wr_data  = {DATA_W{1'b0}};
        o_ram_wr_mask  = {MASK_W{1'b0}};
        if (i_sys_rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (grant_valid_s) begin
                        if (grant_id_s == M_LSU) begin
                            o_m1_req_ready = 1'b1;
                            if (i_m1_req_wr) begin
                                o_ram_wr_en   = 1'b1;
                                o_ram_wr_addr = i_m1_req_addr;
                                o_ram_wr_data = i_m1_req_wdata;
                                o_ram_wr_mask = i_m1_req_wmask;
                            end else begin
                                o_ram_rd_en   = 1'b1;
                                o_ram_rd_addr = i_m1_req_addr;
                            end
                        end else begin
                            o_m0_req_ready = 1'b1;
                            o_ram_rd_en    = 1'b1;
                            o_ram_rd_addr  = i_m0_req_addr;
                        end
                    end else begin
                        o_ram_rd_en = 1'b0;
                    end
                end
                S_RESP: begin
                    if (r_owner == M_LSU) begin
                        o_m1_rsp_valid = 1'b1;
                        o_m1_rsp_data  = r_rsp_data;
                    end else begin
                        o_m0_rsp_valid = 1'b1;
                        o_m0_rsp_data  = r_rsp_data;
                    end
                end
                default: begin
                    o_ram_rd_en = 1'b0;
                end
            endcase
        end else begin
            o_ram_wr_en = 1'b0;
        end
    end

    // Arbiter state machine and response buffer.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= M_IFU;
            r_last_grant <= M_LSU;
            r_rsp_data   <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (grant_valid_s) begin
                        r_rsp_data   <= is_wr_s ? {DATA_W{1'b0}} : i_ram_rd_data;
                        r_owner      <= master_e'(grant_id_s);
                        r_last_grant <= master_e'(grant_id_s);
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_hs_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb with a behavioural byte-masked RAM model.
module tb_ram_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_req_addr, m0_rsp_data;
    logic        m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_data;
    logic [3:0]  m1_req_wmask;
    logic        ram_rd_en, ram_wr_en;
    logic [31:0] ram_rd_addr, ram_rd_data, ram_wr_addr, ram_wr_data;
    logic [3:0]  ram_wr_mask;

    ram_arb dut (
        .i_sys_clk      (clk),
        .i_sys_rst_n    (rst_n),
        .i_m0_req_valid (m0_req_valid),
        .o_m0_req_ready (m0_req_ready),
        .i_m0_req_addr  (m0_req_addr),
        .o_m0_rsp_valid (m0_rsp_valid),
        .i_m0_rsp_ready (m0_rsp_ready),
        .o_m0_rsp_data  (m0_rsp_data),
        .i_m1_req_valid (m1_req_valid),
        .o_m1_req_ready (m1_req_ready),
        .i_m1_req_wr    (m1_req_wr),
        .i_m1_req_addr  (m1_req_addr),
        .i_m1_req_wdata (m1_req_wdata),
        .i_m1_req_wmask (m1_req_wmask),
        .o_m1_rsp_valid (m1_rsp_valid),
        .i_m1_rsp_ready (m1_rsp_ready),
        .o_m1_rsp_data  (m1_rsp_data),
        .o_ram_rd_en    (ram_rd_en),
        .o_ram_rd_addr  (ram_rd_addr),
        .i_ram_rd_data  (ram_rd_data),
        .o_ram_wr_en    (ram_wr_en),
        .o_ram_wr_addr  (ram_wr_addr),
        .o_ram_wr_data  (ram_wr_data),
        .o_ram_wr_mask  (ram_wr_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 16 words, preload port for the bench, byte-masked DUT writes.
    logic [31:0] mem [16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_mask[b]) mem[ram_wr_addr[5:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        ram_rd_data = 32'h0;
        if (ram_rd_en) ram_rd_data = mem[ram_rd_addr[5:2]];
    end

    // Scoreboard of expected responses, in order.
    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_rsp_t;
    exp_rsp_t sb_q[$];

    // Per-cycle expectations written by the stimulus, checked by the monitor.
    logic        exp_en;
    logic        e_m0rr, e_m1rr, e_rd, e_wr, e_v0, e_v1;
    logic [31:0] e_d0, e_d1;
    logic        done;
    logic        end_checked;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic pop_check(input logic port, input logic [31:0] data);
        exp_rsp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp at %0t: port %0d data %h, expected none", $time, port, data);
        end else begin
            e = sb_q.pop_front();
            chk("rsp_port", {31'd0, port}, {31'd0, e.port});
            chk("rsp_data", data, e.data);
        end
    endtask

    // Monitor: per-cycle expectations, response handshakes, final drain check.
    always @(negedge clk) begin
        if (exp_en) begin
            chk("m0_req_ready", {31'd0, m0_req_ready}, {31'd0, e_m0rr});
            chk("m1_req_ready", {31'd0, m1_req_ready}, {31'd0, e_m1rr});
            chk("ram_rd_en",    {31'd0, ram_rd_en},    {31'd0, e_rd});
            chk("ram_wr_en",    {31'd0, ram_wr_en},    {31'd0, e_wr});
            chk("m0_rsp_valid", {31'd0, m0_rsp_valid}, {31'd0, e_v0});
            chk("m1_rsp_valid", {31'd0, m1_rsp_valid}, {31'd0, e_v1});
            chk("m0_rsp_data",  m0_rsp_data, e_d0);
            chk("m1_rsp_data",  m1_rsp_data, e_d1);
        end
        if (m0_rsp_valid && m0_rsp_ready) pop_check(1'b0, m0_rsp_data);
        if (m1_rsp_valid && m1_rsp_ready) pop_check(1'b1, m1_rsp_data);
        if (done && !end_checked) begin
            chk("sb_left", sb_q.size(), 32'd0);
            end_checked = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_en = 1'b0;
    endtask

    task automatic set_exp(input logic m0rr, input logic m1rr, input logic rd, input logic wr,
                           input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1);
        e_m0rr = m0rr; e_m1rr = m1rr; e_rd = rd; e_wr = wr;
        e_v0 = v0; e_v1 = v1; e_d0 = d0; e_d1 = d1;
        exp_en = 1'b1;
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        sb_q.push_back('{port, data});
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; done = 1'b0; end_checked = 1'b0; exp_en = 1'b0;
        pre_we = 1'b0; pre_idx = 4'd0; pre_data = 32'h0;
        rst_n = 1'b0;
        m0_req_valid = 1'b0; m0_req_addr = 32'h0; m0_rsp_ready = 1'b1;
        m1_req_valid = 1'b0; m1_req_wr = 1'b0; m1_req_addr = 32'h0;
        m1_req_wdata = 32'h0; m1_req_wmask = 4'h0; m1_rsp_ready = 1'b1;
        tick();
        // Preload under reset; each cycle also checks the reset-forced outputs.
        preload(4'd1, 32'hDEAD_BEEF);
        preload(4'd2, 32'h2222_2222);
        preload(4'd3, 32'h3333_3333);
        preload(4'd4, 32'hAAAA_AAAA);
        preload(4'd5, 32'h5555_5555);
        preload(4'd6, 32'h6666_6666);
        preload(4'd7, 32'h7777_7777);
        preload(4'd8, 32'h89AB_CDEF);
        rst_n = 1'b1;

        // Single m0 read
        m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0004;
        set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b0, 32'hDEAD_BEEF);
        tick();
        m0_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        tick();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Round-robin with both held valid, starting from reset
        rst_n = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0008;
        m1_req_valid = 1'b1; m1_req_wr = 1'b0; m1_req_addr = 32'h8000_000C;
        for (int k = 0; k < 2; k++) begin
            set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            push(1'b0, 32'h2222_2222);
            tick();
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2222_2222, 32'h0);
            tick();
            set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            push(1'b1, 32'h3333_3333);
            tick();
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3333_3333);
            tick();
        end
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // Masked write then read-back
        m1_req_valid = 1'b1; m1_req_wr = 1'b1; m1_req_addr = 32'h8000_0010;
        m1_req_wdata = 32'h1122_3344; m1_req_wmask = 4'b0101;
        set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'h0);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        m1_req_valid = 1'b1; m1_req_wr = 1'b0;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'hAA22_AA44);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hAA22_AA44);
        tick();

        // Response backpressure on m0 while m1 waits
        m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0014; m0_rsp_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b0, 32'h5555_5555);
        tick();
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b1; m1_req_wr = 1'b0; m1_req_addr = 32'h8000_0018;
        repeat (3) begin
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h0);
            tick();
        end
        m0_rsp_ready = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h0);
        tick();
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'h6666_6666);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h6666_6666);
        tick();

        // Reset while a response is pending, with an m1 write presented
        m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0004; m0_rsp_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        m0_req_valid = 1'b0; rst_n = 1'b0;
        m1_req_valid = 1'b1; m1_req_wr = 1'b1; m1_req_addr = 32'h8000_001C;
        m1_req_wdata = 32'h0000_0000; m1_req_wmask = 4'hF;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1; m0_rsp_ready = 1'b1; m1_req_wr = 1'b0;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'h7777_7777);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h7777_7777);
        tick();

        // Zero-mask write is acked and leaves the word intact
        m1_req_valid = 1'b1; m1_req_wr = 1'b1; m1_req_addr = 32'h8000_0020;
        m1_req_wdata = 32'hFFFF_FFFF; m1_req_wmask = 4'h0;
        set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'h0);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        m1_req_valid = 1'b1; m1_req_wr = 1'b0;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b1, 32'h89AB_CDEF);
        tick();
        m1_req_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h89AB_CDEF);
        tick();

        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        done = 1'b1;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
